// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter that steers the winning requester's word through a
// shared 4:1 mux into a valid/ready output register.

module mux32x4 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end
endmodule

module mux_rr_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [3:0]       eff;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic             cap;
    logic [WIDTH-1:0] mux_y;

    // A requester whose grant pulse is still visible has not yet had a chance to
    // drop its request, so it is masked for exactly that cycle.
    assign eff = req & ~gnt;

    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && eff[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign cap = found && (state == IDLE || out_ready);

    mux32x4 #(.WIDTH(WIDTH)) u_mux (
        .sel (winner),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .y   (mux_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            gnt       <= '0;
            sel       <= '0;
        end else begin
            gnt <= '0;
            if (cap) begin
                out_data  <= mux_y;
                out_valid <= 1'b1;
                gnt       <= 4'b0001 << winner;
                sel       <= winner;
                ptr       <= winner + 2'd1;
                state     <= HOLD;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a cycle-level behavioural model is compared on
// every negedge, and literal expectations pin the key scenarios.

module tb_mux_rr_arbiter;
    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] in0, in1, in2, in3;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Behavioural model: a pending word flag, the last word, and a rotating start index.
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_gnt;
    int          m_sel;

    mux_rr_arbiter #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(int i);
        case (i)
            0:       return in0;
            1:       return in1;
            2:       return in2;
            default: return in3;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_gnt = '0; m_sel = 0;
        end else begin
            int win;
            win = -1;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (win < 0 && req[i] && !m_gnt[i]) win = i;
            end
            if (win >= 0 && (!m_valid || out_ready)) begin
                m_data  = word_of(win);
                m_valid = 1;
                m_gnt   = 4'(1 << win);
                m_sel   = win;
                m_ptr   = (win + 1) % 4;
            end else begin
                m_gnt = '0;
                if (m_valid && out_ready) m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (gnt !== m_gnt) begin
                errors++;
                $display("FAIL model_gnt t=%0t got %b want %b", $time, gnt, m_gnt);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t got %b want %b", $time, out_valid, m_valid);
            end
            checks++;
            if (out_data !== m_data) begin
                errors++;
                $display("FAIL model_data t=%0t got %h want %h", $time, out_data, m_data);
            end
            checks++;
            if (sel !== 2'(m_sel)) begin
                errors++;
                $display("FAIL model_sel t=%0t got %0d want %0d", $time, sel, m_sel);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_out(string name, logic [3:0] g, logic [1:0] s, logic [31:0] d, logic v);
        expect_eq({name, "_gnt"}, 32'(gnt), 32'(g));
        expect_eq({name, "_sel"}, 32'(sel), 32'(s));
        expect_eq({name, "_data"}, out_data, d);
        expect_eq({name, "_valid"}, 32'(out_valid), 32'(v));
    endtask

    initial begin
        logic [31:0] b [4];
        reset = 1; req = 4'b1111; out_ready = 1;
        in0 = 32'hA000_0000; in1 = 32'hA111_1111; in2 = 32'hA222_2222; in3 = 32'hA333_3333;

        // Reset held with all requesting
        tick();
        check_en = 1;
        tick();
        expect_out("reset", 4'b0000, 2'd0, 32'h0, 1'b0);
        reset = 0;
        tick(); expect_out("rr0", 4'b0001, 2'd0, 32'hA000_0000, 1'b1);
        tick(); expect_out("rr1", 4'b0010, 2'd1, 32'hA111_1111, 1'b1);
        tick(); expect_out("rr2", 4'b0100, 2'd2, 32'hA222_2222, 1'b1);
        tick(); expect_out("rr3", 4'b1000, 2'd3, 32'hA333_3333, 1'b1);
        tick(); expect_out("rr4", 4'b0001, 2'd0, 32'hA000_0000, 1'b1);
        req = 4'b0000;
        tick(); expect_out("rr_drain", 4'b0000, 2'd0, 32'hA000_0000, 1'b0);

        // Single requester
        req = 4'b0100; in2 = 32'hDEAD_BEEF;
        tick(); expect_out("single", 4'b0100, 2'd2, 32'hDEAD_BEEF, 1'b1);
        req = 4'b0000;
        tick(); expect_out("single_drop", 4'b0000, 2'd2, 32'hDEAD_BEEF, 1'b0);

        // Backpressure
        req = 4'b0010; in1 = 32'h1111_0001;
        tick(); expect_out("bp_g1", 4'b0010, 2'd1, 32'h1111_0001, 1'b1);
        req = 4'b1011; in1 = 32'h1111_0002; in3 = 32'h3333_0003; out_ready = 0;
        for (int c = 0; c < 5; c++) begin
            tick(); expect_out("bp_hold", 4'b0000, 2'd1, 32'h1111_0001, 1'b1);
        end
        out_ready = 1;
        tick(); expect_out("bp_g3", 4'b1000, 2'd3, 32'h3333_0003, 1'b1);
        req = 4'b0000;
        tick(); expect_out("bp_drain", 4'b0000, 2'd3, 32'h3333_0003, 1'b0);

        // Back-to-back, each requester drops after its grant
        b[0] = 32'hB0B0_0000; b[1] = 32'hB1B1_1111; b[2] = 32'hB2B2_2222; b[3] = 32'hB3B3_3333;
        in0 = b[0]; in1 = b[1]; in2 = b[2]; in3 = b[3];
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("b2b", 4'(1 << i), 2'(i), b[i], 1'b1);
            req[i] = 1'b0;
        end
        tick(); expect_out("b2b_drain", 4'b0000, 2'd3, b[3], 1'b0);

        // Stale request held one cycle past its grant
        req = 4'b0001; in0 = 32'hC0C0_C0C0;
        tick(); expect_out("stale_g", 4'b0001, 2'd0, 32'hC0C0_C0C0, 1'b1);
        tick(); expect_out("stale_masked", 4'b0000, 2'd0, 32'hC0C0_C0C0, 1'b0);
        in0 = 32'hC1C1_C1C1;
        tick(); expect_out("stale_regrant", 4'b0001, 2'd0, 32'hC1C1_C1C1, 1'b1);
        req = 4'b0000;
        tick(); expect_out("stale_drain", 4'b0000, 2'd0, 32'hC1C1_C1C1, 1'b0);

        // Reset while a word is held under backpressure
        req = 4'b0100; in2 = 32'hE2E2_E2E2; out_ready = 0;
        tick(); expect_out("mid_g", 4'b0100, 2'd2, 32'hE2E2_E2E2, 1'b1);
        req = 4'b0000;
        tick(); expect_out("mid_hold", 4'b0000, 2'd2, 32'hE2E2_E2E2, 1'b1);
        reset = 1;
        tick(); expect_out("mid_reset", 4'b0000, 2'd0, 32'h0, 1'b0);
        reset = 0; out_ready = 1;
        tick(); expect_out("post_reset_idle", 4'b0000, 2'd0, 32'h0, 1'b0);
        req = 4'b1111; in0 = 32'hF0F0_F0F0; in3 = 32'hF3F3_F3F3;
        tick(); expect_out("post_reset_ptr", 4'b0001, 2'd0, 32'hF0F0_F0F0, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
